// File: rtl/wb_ctrl_pkg.sv
// wb_ctrl_pkg: shared types and defaults for the write-back / data-memory controller.
package wb_ctrl_pkg;

   // Default widths and timeout
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_REG_AW      = 5;
   localparam int DEF_TIMEOUT_CYC = 16;

   // Legacy-compatible state encodings, wrapped by the enum below
   localparam logic [1:0] IDLE_ENC   = 2'd0;
   localparam logic [1:0] ACCESS_ENC = 2'd1;
   localparam logic [1:0] WB_ENC     = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = IDLE_ENC,
      ACCESS = ACCESS_ENC,
      WB     = WB_ENC
   } wbStateE;

   // Write-back mux select values
   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   // A decoded instruction that needs the data memory
   function automatic logic isMemInst(input logic valid, input logic ld, input logic st);
      return valid & (ld | st);
   endfunction

endpackage

// File: rtl/wb_timeout.sv
// wb_timeout: counts cycles spent in ACCESS and flags the cycle on which
// the access has lasted TIMEOUT_CYC cycles. Used only when WB_CTRL_TIMEOUT_EN
// is defined.
module wb_timeout
   import wb_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
   input  logic clk,
   input  logic reset,
   input  logic inAccess,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_r;
   logic             expire_s;

   // Last ACCESS cycle allowed: counter holds the number of earlier ACCESS cycles
   always_comb begin
      expire_s = 1'b0;
      if (inAccess && (cnt_r == CNT_W'(TIMEOUT_CYC - 1))) begin
         expire_s = 1'b1;
      end else begin
         expire_s = 1'b0;
      end
   end

   // Cycle counter: runs in ACCESS, clears outside it and on expiry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (!inAccess || expire_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   assign expire = expire_s;

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back and data-memory controller. ALU instructions write back
// combinationally in IDLE; loads/stores run IDLE -> ACCESS -> WB with a
// req/ack handshake while stall holds the PC.
// Optional feature macro: WB_CTRL_TIMEOUT_EN (bus-error timeout in ACCESS).
module wb_ctrl
   import wb_ctrl_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int REG_AW      = DEF_REG_AW,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              instValid,
   input  logic              isLoad,
   input  logic              isStore,
   input  logic              regWrite,
   input  logic [REG_AW-1:0] rdAddr,
   input  logic [DATA_W-1:0] aluResult,
   input  logic [DATA_W-1:0] storeData,
   output logic              dmemReq,
   output logic              dmemWe,
   output logic [DATA_W-1:0] dmemAddr,
   output logic [DATA_W-1:0] dmemWdata,
   input  logic [DATA_W-1:0] dmemRdata,
   input  logic              dmemAck,
   output logic              stall,
   output logic              wbSel,
   output logic [DATA_W-1:0] memData,
   output logic              rfWe,
   output logic [REG_AW-1:0] rfAddr,
   output logic              busErr
);

   wbStateE           state_r;
   wbStateE           nextState_s;
   logic              memInst_s;
   logic              aluInst_s;
   logic              storeSel_s;
   logic              timeout_s;
   logic              accessDone_s;
   logic [REG_AW-1:0] latRd_r;
   logic              latLoad_r;
   logic              latRegWrite_r;
   logic [DATA_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [DATA_W-1:0] memData_r;
   logic              dmemReq_r;
   logic              dmemWe_r;
   logic              busErr_r;
   logic              stall_s;
   logic              wbSel_s;
   logic              rfWeRaw_s;
   logic [REG_AW-1:0] rfAddr_s;

   assign memInst_s  = isMemInst(instValid, isLoad, isStore);
   assign aluInst_s  = instValid & ~isLoad & ~isStore;
   // Load wins when both class bits are set
   assign storeSel_s = isStore & ~isLoad;

`ifdef WB_CTRL_TIMEOUT_EN
   logic expire_s;

   wb_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) uTimeout (
      .clk      (clk),
      .reset    (reset),
      .inAccess (state_r == ACCESS),
      .expire   (expire_s)
   );

   // A same-cycle ack takes priority over the timeout
   assign timeout_s = expire_s & ~dmemAck;
`else
   // Timeout disabled: ACCESS waits for the ack indefinitely
   assign timeout_s = (TIMEOUT_CYC < 0) ? 1'b1 : 1'b0;
`endif

   assign accessDone_s = dmemAck | timeout_s;

   // Next-state logic
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (memInst_s) begin
               nextState_s = ACCESS;
            end else begin
               nextState_s = IDLE;
            end
         end
         ACCESS: begin
            if (accessDone_s) begin
               nextState_s = WB;
            end else begin
               nextState_s = ACCESS;
            end
         end
         WB:      nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
   end

   // Combinational stall / write-back controls per state
   always_comb begin
      stall_s   = 1'b0;
      wbSel_s   = WB_SEL_ALU;
      rfWeRaw_s = 1'b0;
      rfAddr_s  = rdAddr;
      case (state_r)
         IDLE: begin
            stall_s   = memInst_s;
            wbSel_s   = WB_SEL_ALU;
            rfWeRaw_s = aluInst_s & regWrite;
            rfAddr_s  = rdAddr;
         end
         ACCESS: begin
            stall_s   = 1'b1;
            wbSel_s   = WB_SEL_ALU;
            rfWeRaw_s = 1'b0;
            rfAddr_s  = latRd_r;
         end
         WB: begin
            stall_s   = 1'b0;
            wbSel_s   = WB_SEL_MEM;
            rfWeRaw_s = latLoad_r & latRegWrite_r;
            rfAddr_s  = latRd_r;
         end
         default: begin
            stall_s   = 1'b0;
            wbSel_s   = WB_SEL_ALU;
            rfWeRaw_s = 1'b0;
            rfAddr_s  = rdAddr;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Capture the memory instruction's operands when it is accepted in IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r        <= '0;
         wdata_r       <= '0;
         latRd_r       <= '0;
         latLoad_r     <= 1'b0;
         latRegWrite_r <= 1'b0;
      end else if ((state_r == IDLE) && memInst_s) begin
         addr_r        <= aluResult;
         wdata_r       <= storeData;
         latRd_r       <= rdAddr;
         latLoad_r     <= isLoad;
         latRegWrite_r <= regWrite;
      end else begin
         addr_r        <= addr_r;
         wdata_r       <= wdata_r;
         latRd_r       <= latRd_r;
         latLoad_r     <= latLoad_r;
         latRegWrite_r <= latRegWrite_r;
      end
   end

   // Registered request/write strobes, high exactly for the ACCESS cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dmemReq_r <= 1'b0;
         dmemWe_r  <= 1'b0;
      end else if (nextState_s == ACCESS) begin
         dmemReq_r <= 1'b1;
         dmemWe_r  <= (state_r == IDLE) ? storeSel_s : dmemWe_r;
      end else begin
         dmemReq_r <= 1'b0;
         dmemWe_r  <= 1'b0;
      end
   end

   // Load data capture on ack; a timed-out access returns zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         memData_r <= '0;
      end else if ((state_r == ACCESS) && dmemAck && latLoad_r) begin
         memData_r <= dmemRdata;
      end else if ((state_r == ACCESS) && timeout_s) begin
         memData_r <= '0;
      end else begin
         memData_r <= memData_r;
      end
   end

   // One-cycle bus-error pulse, coincident with the WB that follows a timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busErr_r <= 1'b0;
      end else if ((state_r == ACCESS) && timeout_s) begin
         busErr_r <= 1'b1;
      end else begin
         busErr_r <= 1'b0;
      end
   end

   assign dmemReq   = dmemReq_r;
   assign dmemWe    = dmemWe_r;
   assign dmemAddr  = addr_r;
   assign dmemWdata = wdata_r;
   assign memData   = memData_r;
   assign busErr    = busErr_r;
   assign stall     = stall_s;
   assign wbSel     = wbSel_s;
   assign rfAddr    = rfAddr_s;
   // Register 0 is hard-wired; never write it
   assign rfWe      = rfWeRaw_s & (rfAddr_s != {REG_AW{1'b0}});

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed bench for wb_ctrl with a transaction-level reference
// model checked every cycle, plus hand-computed literal checks.
module tb_wb_ctrl;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int TO = 16;
`ifdef WB_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          instValid, isLoad, isStore, regWrite;
   logic [AW-1:0] rdAddr;
   logic [DW-1:0] aluResult, storeData, dmemRdata;
   logic          dmemAck;
   logic          dmemReq, dmemWe, stall, wbSel, rfWe, busErr;
   logic [DW-1:0] dmemAddr, dmemWdata, memData;
   logic [AW-1:0] rfAddr;

   int nCmp = 0;
   int nBad = 0;
   bit chkEn = 1'b0;

   wb_ctrl #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .instValid(instValid), .isLoad(isLoad),
      .isStore(isStore), .regWrite(regWrite), .rdAddr(rdAddr),
      .aluResult(aluResult), .storeData(storeData), .dmemReq(dmemReq),
      .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
      .dmemRdata(dmemRdata), .dmemAck(dmemAck), .stall(stall), .wbSel(wbSel),
      .memData(memData), .rfWe(rfWe), .rfAddr(rfAddr), .busErr(busErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // mBusy: a memory op is outstanding; mWb: its write-back cycle is now.
   bit          mBusy, mWb, mLd, mWe, mRw, mBusErr;
   logic [DW-1:0] mAddr, mWdata, mMemData;
   logic [AW-1:0] mRd;
   int          mWait;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mBusy <= 1'b0; mWb <= 1'b0; mLd <= 1'b0; mWe <= 1'b0; mRw <= 1'b0;
         mBusErr <= 1'b0; mAddr <= '0; mWdata <= '0; mMemData <= '0;
         mRd <= '0; mWait <= 0;
      end else begin
         mBusErr <= 1'b0;
         if (mWb) begin
            mWb <= 1'b0;
         end else if (mBusy) begin
            if (dmemAck) begin
               mBusy <= 1'b0; mWb <= 1'b1; mWait <= 0;
               if (mLd) mMemData <= dmemRdata;
            end else if (TO_EN && (mWait == TO - 1)) begin
               mBusy <= 1'b0; mWb <= 1'b1; mWait <= 0;
               mMemData <= '0; mBusErr <= 1'b1;
            end else begin
               mWait <= mWait + 1;
            end
         end else if (instValid && (isLoad || isStore)) begin
            mBusy <= 1'b1; mLd <= isLoad; mWe <= !isLoad; mRw <= regWrite;
            mRd <= rdAddr; mAddr <= aluResult; mWdata <= storeData; mWait <= 0;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic          eStall, eSel, eWe;
      logic [AW-1:0] eAddr;
      if (chkEn && !reset) begin
         if (mWb) begin
            eStall = 1'b0; eSel = 1'b1; eAddr = mRd; eWe = mLd & mRw;
         end else if (mBusy) begin
            eStall = 1'b1; eSel = 1'b0; eAddr = mRd; eWe = 1'b0;
         end else begin
            eStall = instValid & (isLoad | isStore);
            eSel   = 1'b0;
            eAddr  = rdAddr;
            eWe    = instValid & ~isLoad & ~isStore & regWrite;
         end
         if (eAddr == '0) eWe = 1'b0;
         chk("stall", stall, eStall);
         chk("wbSel", wbSel, eSel);
         chk("rfAddr", rfAddr, eAddr);
         chk("rfWe", rfWe, eWe);
         chk("dmemReq", dmemReq, mBusy);
         chk("dmemWe", dmemWe, mBusy & mWe);
         chk("memData", memData, mMemData);
         chk("busErr", busErr, mBusErr);
         if (mBusy) begin
            chk("dmemAddr", dmemAddr, mAddr);
            chk("dmemWdata", dmemWdata, mWdata);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic ld, input logic st, input logic rw,
                        input logic [AW-1:0] rd, input logic [DW-1:0] alu, input logic [DW-1:0] sd);
      instValid = v; isLoad = ld; isStore = st; regWrite = rw;
      rdAddr = rd; aluResult = alu; storeData = sd;
   endtask

   // Present a memory op, ack it k cycles after presentation; returns in WB
   task automatic memOp(input logic ld, input logic st, input logic rw, input logic [AW-1:0] rd,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wd, input int k,
                        input logic [DW-1:0] rdata, input bit holdAck,
                        output int nStall, output int nReq);
      drive(1'b1, ld, st, rw, rd, addr, wd);
      nStall = 0;
      nReq   = 0;
      for (int c = 0; c <= k; c++) begin
         if (c == k) begin
            dmemAck = 1'b1;
            dmemRdata = rdata;
         end
         @(negedge clk);
         if (stall) nStall++;
         if (dmemReq) nReq++;
         if (c == 1) begin
            chk("acc_we", dmemWe, st & ~ld);
            chk("acc_addr", dmemAddr, addr);
            chk("acc_wdata", dmemWdata, wd);
         end
         tick();
      end
      if (!holdAck) dmemAck = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ns, nr;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      dmemAck = 1'b0;
      dmemRdata = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dmemReq", dmemReq, 1'b0);
      chk("rst_dmemAddr", dmemAddr, 32'h0);
      chk("rst_memData", memData, 32'h0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_busErr", busErr, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      chkEn = 1'b1;

      // ALU instruction writes back in the same cycle
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
      @(negedge clk);
      chk("alu_rfWe", rfWe, 1'b1);
      chk("alu_rfAddr", rfAddr, 5'd5);
      chk("alu_wbSel", wbSel, 1'b0);
      chk("alu_stall", stall, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h99, 32'h0);
      @(negedge clk);
      chk("alu_r0_rfWe", rfWe, 1'b0);
      tick();

      // Load, ack 3 cycles after presentation
      memOp(1'b1, 1'b0, 1'b1, 5'd7, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0, ns, nr);
      chk("ld_stall_cycles", ns, 4);
      chk("ld_req_cycles", nr, 3);
      @(negedge clk);
      chk("ld_wb_rfWe", rfWe, 1'b1);
      chk("ld_wb_rfAddr", rfAddr, 5'd7);
      chk("ld_wb_wbSel", wbSel, 1'b1);
      chk("ld_wb_memData", memData, 32'hDEADBEEF);
      chk("ld_wb_stall", stall, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();

      // Store, ack 1 cycle after the request
      memOp(1'b0, 1'b1, 1'b0, 5'd3, 32'h80, 32'hCAFE, 2, 32'h5555AAAA, 1'b0, ns, nr);
      chk("st_req_cycles", nr, 2);
      @(negedge clk);
      chk("st_wb_rfWe", rfWe, 1'b0);
      chk("st_wb_stall", stall, 1'b0);
      chk("st_wb_memData", memData, 32'hDEADBEEF);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();

      // Load to r0, ack held high for several cycles
      memOp(1'b1, 1'b0, 1'b1, 5'd0, 32'h44, 32'h0, 1, 32'h13572468, 1'b1, ns, nr);
      @(negedge clk);
      chk("ld0_wb_rfWe", rfWe, 1'b0);
      chk("ld0_wb_memData", memData, 32'h13572468);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) tick();
      @(negedge clk);
      chk("held_ack_req", dmemReq, 1'b0);
      chk("held_ack_stall", stall, 1'b0);
      dmemAck = 1'b0;
      tick();

      // Stray ack in IDLE
      dmemAck = 1'b1;
      dmemRdata = 32'hFFFF0000;
      repeat (3) tick();
      dmemAck = 1'b0;
      @(negedge clk);
      chk("stray_req", dmemReq, 1'b0);
      chk("stray_memData", memData, 32'h13572468);
      tick();

      // isLoad & isStore together behave as a load
      memOp(1'b1, 1'b1, 1'b1, 5'd3, 32'h100, 32'h55, 1, 32'h0BADF00D, 1'b0, ns, nr);
      @(negedge clk);
      chk("both_wb_rfWe", rfWe, 1'b1);
      chk("both_wb_memData", memData, 32'h0BADF00D);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();

`ifndef WB_CTRL_TIMEOUT_EN
      // Without the timeout, a long wait simply completes
      memOp(1'b1, 1'b0, 1'b1, 5'd9, 32'h200, 32'h0, 20, 32'h00C0FFEE, 1'b0, ns, nr);
      chk("long_req_cycles", nr, 20);
      @(negedge clk);
      chk("long_wb_memData", memData, 32'h00C0FFEE);
      chk("long_wb_busErr", busErr, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
`else
      // Timeout: no ack for 16 ACCESS cycles
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h200, 32'h0);
      repeat (16) tick();
      @(negedge clk);
      chk("to_last_acc_busErr", busErr, 1'b0);
      chk("to_last_acc_stall", stall, 1'b1);
      tick();
      @(negedge clk);
      chk("to_busErr", busErr, 1'b1);
      chk("to_wbSel", wbSel, 1'b1);
      chk("to_rfWe", rfWe, 1'b1);
      chk("to_memData", memData, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      chk("to_pulse_end", busErr, 1'b0);
      tick();
      // Ack on the timeout cycle wins
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h204, 32'h0);
      repeat (16) tick();
      dmemAck = 1'b1;
      dmemRdata = 32'h00000077;
      tick();
      dmemAck = 1'b0;
      @(negedge clk);
      chk("tie_busErr", busErr, 1'b0);
      chk("tie_memData", memData, 32'h00000077);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
`endif

      // Reset asserted while in ACCESS
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 32'h300, 32'h0);
      repeat (2) tick();
      #2;
      reset = 1'b1;
      #1;
      chk("rstacc_dmemReq", dmemReq, 1'b0);
      chk("rstacc_memData", memData, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      @(posedge clk); #3;
      reset = 1'b0;
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 32'h42, 32'h0);
      @(negedge clk);
      chk("postrst_stall", stall, 1'b0);
      chk("postrst_rfWe", rfWe, 1'b1);
      chk("postrst_rfAddr", rfAddr, 5'd6);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      repeat (2) tick();

      chkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
